// File: rtl/i2c_reg_reader.sv
// i2c_reg_reader: bit-level I2C master that reads one device register.
// Sequence: S, {addr,W}, reg_num, Sr, {addr,R}, 1..4 data bytes, P.
// SCL/SDA are open-drain; o_*_t = 1 releases the line, 0 pulls it low.
module i2c_reg_reader #(
    parameter int CLK_FREQ = 100000000,
    parameter int I2C_FREQ = 100000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [6:0]  i_dev_addr,
    input  logic [7:0]  i_reg_num,
    input  logic [2:0]  i_read_len,
    input  logic        i_start,
    output logic [1:0]  o_status,
    output logic [31:0] o_rx_data,
    input  logic        i_scl,
    input  logic        i_sda,
    output logic        o_scl_t,
    output logic        o_sda_t
);
    // Clocks per quarter-bit; must be at least 2 so the synchronized SCL
    // reflects our own low drive before the stretch check in q1.
    localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);
    localparam int QW = $clog2(QDIV);
    localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_WBYTE, ST_WACK,
        ST_RSTART, ST_RBYTE, ST_MACK, ST_STOP
    } state_t;

    // Start handshake: i_start is a one-cycle strobe that is accepted only
    // while o_status[0] (idle) is 1; a strobe while busy is dropped.
    // Completion is signalled by idle returning to 1.

    logic [1:0]    scl_sync, sda_sync;
    logic          scl_s, sda_s;
    state_t        state;
    logic [1:0]    phase;
    logic [QW-1:0] qcnt;
    logic          tick, hold, adv, mid;
    logic [2:0]    bit_cnt;
    logic [1:0]    wbyte_idx;
    logic [2:0]    rd_cnt, len_r;
    logic [6:0]    addr_r;
    logic [7:0]    reg_r, shreg, rshift;
    logic          ack_bit, idle, fault;
    logic          want_scl, want_sda;

    // Two-flop synchronizers for the asynchronous pin inputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], i_scl};
            sda_sync <= {sda_sync[0], i_sda};
        end
    end

    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];

    // q1 releases SCL; a slave holding it low freezes the quarter counter
    assign tick = (qcnt == QLAST);
    assign hold = (phase == 2'd1) && !scl_s;
    assign adv  = tick && !hold;
    assign mid  = (phase == 2'd1) || (phase == 2'd2);

    assign o_status = {fault, idle};

    // Desired line levels for the current state and quarter
    always_comb begin
        want_scl = 1'b1;
        want_sda = 1'b1;
        case (state)
            ST_IDLE: begin
                want_scl = 1'b1;
                want_sda = 1'b1;
            end
            ST_START: begin
                want_scl = (phase != 2'd3);
                want_sda = (phase < 2'd2);
            end
            ST_RSTART: begin
                want_scl = mid;
                want_sda = (phase < 2'd2);
            end
            ST_WBYTE: begin
                want_scl = mid;
                want_sda = shreg[7];
            end
            ST_WACK, ST_RBYTE: begin
                want_scl = mid;
                want_sda = 1'b1;
            end
            ST_MACK: begin
                want_scl = mid;
                want_sda = (rd_cnt == len_r);
            end
            ST_STOP: begin
                want_scl = (phase != 2'd0);
                want_sda = (phase == 2'd3);
            end
            default: begin
                want_scl = 1'b1;
                want_sda = 1'b1;
            end
        endcase
    end

    // Transfer FSM, quarter timing, data path and registered line drivers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            phase     <= 2'd0;
            qcnt      <= '0;
            bit_cnt   <= 3'd0;
            wbyte_idx <= 2'd0;
            rd_cnt    <= 3'd0;
            len_r     <= 3'd0;
            addr_r    <= 7'd0;
            reg_r     <= 8'd0;
            shreg     <= 8'd0;
            rshift    <= 8'd0;
            ack_bit   <= 1'b0;
            idle      <= 1'b1;
            fault     <= 1'b0;
            o_rx_data <= 32'd0;
            o_scl_t   <= 1'b1;
            o_sda_t   <= 1'b1;
        end else begin
            o_scl_t <= want_scl;
            o_sda_t <= want_sda;
            if (state == ST_IDLE) begin
                qcnt  <= '0;
                phase <= 2'd0;
                if (i_start) begin
                    addr_r    <= i_dev_addr;
                    reg_r     <= i_reg_num;
                    len_r     <= i_read_len;
                    o_rx_data <= 32'd0;
                    if (i_read_len == 3'd0 || i_read_len > 3'd4) begin
                        fault <= 1'b1;
                    end else begin
                        fault <= 1'b0;
                        idle  <= 1'b0;
                        state <= ST_START;
                    end
                end
            end else begin
                if (!hold) qcnt <= tick ? '0 : qcnt + 1'b1;
                if (adv) begin
                    if (phase == 2'd2) begin
                        if (state == ST_WACK) ack_bit <= sda_s;
                        if (state == ST_RBYTE) rshift <= {rshift[6:0], sda_s};
                    end
                    if (phase != 2'd3) begin
                        phase <= phase + 2'd1;
                    end else begin
                        phase <= 2'd0;
                        case (state)
                            ST_START: begin
                                state     <= ST_WBYTE;
                                shreg     <= {addr_r, 1'b0};
                                bit_cnt   <= 3'd0;
                                wbyte_idx <= 2'd0;
                            end
                            ST_WBYTE: begin
                                if (bit_cnt == 3'd7) begin
                                    state <= ST_WACK;
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                    shreg   <= {shreg[6:0], 1'b0};
                                end
                            end
                            ST_WACK: begin
                                if (ack_bit) begin
                                    fault <= 1'b1;
                                    state <= ST_STOP;
                                end else if (wbyte_idx == 2'd0) begin
                                    state     <= ST_WBYTE;
                                    shreg     <= reg_r;
                                    bit_cnt   <= 3'd0;
                                    wbyte_idx <= 2'd1;
                                end else if (wbyte_idx == 2'd1) begin
                                    state <= ST_RSTART;
                                end else begin
                                    state   <= ST_RBYTE;
                                    bit_cnt <= 3'd0;
                                    rd_cnt  <= 3'd0;
                                end
                            end
                            ST_RSTART: begin
                                state     <= ST_WBYTE;
                                shreg     <= {addr_r, 1'b1};
                                bit_cnt   <= 3'd0;
                                wbyte_idx <= 2'd2;
                            end
                            ST_RBYTE: begin
                                if (bit_cnt == 3'd7) begin
                                    o_rx_data <= {o_rx_data[23:0], rshift};
                                    rd_cnt    <= rd_cnt + 3'd1;
                                    state     <= ST_MACK;
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                end
                            end
                            ST_MACK: begin
                                if (rd_cnt == len_r) begin
                                    state <= ST_STOP;
                                end else begin
                                    state   <= ST_RBYTE;
                                    bit_cnt <= 3'd0;
                                end
                            end
                            ST_STOP: begin
                                state <= ST_IDLE;
                                idle  <= 1'b1;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
            end
        end
    end

endmodule
